// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- MBIST sequencer driving an external up/down address counter (optional diagnostics: MBIST_DIAG_EN)
module mbist_march_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              ctr_ld,
    output logic              ctr_u_d,
    output logic              ctr_cen,
    output logic [ADDR_W-1:0] ctr_d_in,
    input  logic [ADDR_W-1:0] ctr_q,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MBIST_DIAG_EN
    ,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_syndrome,
    output logic [7:0]        fail_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0] LAST_ELEM = 3'd5;

    state_t      state, state_d;
    logic [2:0]  elem, elem_d;
    logic        op_idx, op_idx_d;
    logic        fail_q;
    logic        cmp_valid;
    logic        cmp_exp;

    logic        elem_up;
    logic        op_is_wr;
    logic        op_bit;
    logic        op_last;
    logic        at_end;
    logic        start_acc;
    logic        rd_cycle;
    logic        miscompare;

    // Decode the current March C- element/op into direction, access type and data bit
    always_comb begin
        elem_up  = !((elem == 3'd3) || (elem == 3'd4));
        op_is_wr = 1'b0;
        op_bit   = 1'b0;
        op_last  = 1'b1;
        case (elem)
            3'd0: begin
                op_is_wr = 1'b1;
                op_bit   = 1'b0;
                op_last  = 1'b1;
            end
            3'd5: begin
                op_is_wr = 1'b0;
                op_bit   = 1'b0;
                op_last  = 1'b1;
            end
            default: begin
                // Elements 1..4 are (read v, write ~v); elements 2 and 4 read ones
                op_is_wr = op_idx;
                op_bit   = ((elem == 3'd2) || (elem == 3'd4)) ^ op_idx;
                op_last  = op_idx;
            end
        endcase
    end

    assign at_end     = elem_up ? (ctr_q == {ADDR_W{1'b1}}) : (ctr_q == {ADDR_W{1'b0}});
    assign start_acc  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign rd_cycle   = (state == ST_OP) && !op_is_wr;
    assign miscompare = cmp_valid && (mem_rdata != {DATA_W{cmp_exp}});

    assign busy = (state == ST_LOAD) || (state == ST_OP) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign fail = fail_q;

    // State, element and op index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            elem   <= 3'd0;
            op_idx <= 1'b0;
        end else begin
            state  <= state_d;
            elem   <= elem_d;
            op_idx <= op_idx_d;
        end
    end

    // Next-state logic and Moore/Mealy drive of counter and SRAM strobes
    always_comb begin
        state_d   = state;
        elem_d    = elem;
        op_idx_d  = op_idx;
        ctr_ld    = 1'b0;
        ctr_cen   = 1'b0;
        ctr_u_d   = 1'b1;
        ctr_d_in  = {ADDR_W{1'b0}};
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = {DATA_W{1'b0}};
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    elem_d   = 3'd0;
                    op_idx_d = 1'b0;
                end
            end
            ST_LOAD: begin
                ctr_cen  = 1'b1;
                ctr_ld   = 1'b1;
                ctr_u_d  = elem_up;
                ctr_d_in = elem_up ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};
                op_idx_d = 1'b0;
                state_d  = ST_OP;
            end
            ST_OP: begin
                mem_cs    = 1'b1;
                mem_we    = op_is_wr;
                mem_wdata = {DATA_W{op_bit}};
                if (!op_last) begin
                    op_idx_d = 1'b1;
                end else if (!at_end) begin
                    // Step to the next address; the counter output is the SRAM address
                    ctr_cen  = 1'b1;
                    ctr_u_d  = elem_up;
                    op_idx_d = 1'b0;
                end else begin
                    // End address reached: the counter is left where it is
                    op_idx_d = 1'b0;
                    if (elem == LAST_ELEM) begin
                        state_d = ST_DRAIN;
                    end else begin
                        elem_d  = elem + 3'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                // One extra cycle so the final read's data can be compared
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read compare pipeline: read data returns one cycle after the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid <= 1'b0;
            cmp_exp   <= 1'b0;
        end else begin
            cmp_valid <= rd_cycle;
            cmp_exp   <= rd_cycle ? op_bit : 1'b0;
        end
    end

    // Sticky fail flag, cleared only by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= 1'b0;
        end else if (start_acc) begin
            fail_q <= 1'b0;
        end else if (miscompare) begin
            fail_q <= 1'b1;
        end
    end

`ifdef MBIST_DIAG_EN
    logic [ADDR_W-1:0] cmp_addr;
    logic [2:0]        cmp_elem;

    // Carry the address and element of each read alongside its expected bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_addr <= {ADDR_W{1'b0}};
            cmp_elem <= 3'd0;
        end else if (rd_cycle) begin
            cmp_addr <= ctr_q;
            cmp_elem <= elem;
        end
    end

    // Freeze details of the first miscompare and count all of them (saturating)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr     <= {ADDR_W{1'b0}};
            fail_elem     <= 3'd0;
            fail_syndrome <= {DATA_W{1'b0}};
            fail_cnt      <= 8'd0;
        end else if (start_acc) begin
            fail_addr     <= {ADDR_W{1'b0}};
            fail_elem     <= 3'd0;
            fail_syndrome <= {DATA_W{1'b0}};
            fail_cnt      <= 8'd0;
        end else if (miscompare) begin
            if (!fail_q) begin
                fail_addr     <= cmp_addr;
                fail_elem     <= cmp_elem;
                fail_syndrome <= mem_rdata ^ {DATA_W{cmp_exp}};
            end
            if (fail_cnt != 8'hFF) begin
                fail_cnt <= fail_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - directed self-checking bench for mbist_march_ctrl with counter and SRAM models
module tb_mbist_march_ctrl;

    localparam int AW  = 2;
    localparam int DW  = 8;
    localparam int NW  = 4;
    localparam int LAT = 10 * NW + 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, fail;
    logic          ctr_ld, ctr_u_d, ctr_cen;
    logic [AW-1:0] ctr_d_in;
    logic [AW-1:0] ctr_q;
    logic          mem_cs, mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef MBIST_DIAG_EN
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_syndrome;
    logic [7:0]    fail_cnt;
`endif

    logic          stuck;
    logic [DW-1:0] mem [NW];

    int checks = 0;
    int errors = 0;

    logic          tr_q    [64];
    logic [AW-1:0] tr_addr [64];
    logic          tr_cs   [64];
    logic          tr_we   [64];
    logic          tr_ld   [64];
    logic          tr_ud   [64];
    logic          tr_cen  [64];
    logic          tr_busy [64];
    logic          tr_done [64];
    logic          tr_fail [64];
    logic [AW-1:0] tr_din  [64];
    logic [DW-1:0] tr_wd   [64];

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .ctr_ld        (ctr_ld),
        .ctr_u_d       (ctr_u_d),
        .ctr_cen       (ctr_cen),
        .ctr_d_in      (ctr_d_in),
        .ctr_q         (ctr_q),
        .mem_cs        (mem_cs),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
`ifdef MBIST_DIAG_EN
        ,
        .fail_addr     (fail_addr),
        .fail_elem     (fail_elem),
        .fail_syndrome (fail_syndrome),
        .fail_cnt      (fail_cnt)
`endif
    );

    // Up/down address counter model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctr_q <= '0;
        else if (ctr_cen) ctr_q <= ctr_ld ? ctr_d_in : (ctr_u_d ? ctr_q + 2'd1 : ctr_q - 2'd1);
    end

    // Synchronous single-port SRAM model with optional stuck-at-1 on bit 0 of word 2
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[ctr_q] <= mem_wdata;
            else mem_rdata <= mem[ctr_q] | ((stuck && ctr_q == 2'd2) ? 8'h01 : 8'h00);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic record(input int k);
        if (k < 64) begin
            tr_addr[k] = ctr_q;   tr_cs[k]   = mem_cs;  tr_we[k]   = mem_we;
            tr_ld[k]   = ctr_ld;  tr_ud[k]   = ctr_u_d; tr_cen[k]  = ctr_cen;
            tr_busy[k] = busy;    tr_done[k] = done;    tr_fail[k] = fail;
            tr_din[k]  = ctr_d_in; tr_wd[k]  = mem_wdata; tr_q[k]   = 1'b1;
        end
    endtask

    // Pulse (or hold) start, then count edges until done with a bounded wait
    task automatic run_test(input bit hold, output int lat, output int busy_cnt);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        record(0);
        lat = -1;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (hold && k == LAT) start = 1'b0;
            record(k);
            if (done) lat = k;
            else if (busy) busy_cnt++;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, bcnt, ldn;
        rst_n = 1'b0;
        start = 1'b0;
        stuck = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_cen", ctr_cen, 0);
        chk("rst_ld", ctr_ld, 0);
        chk("rst_ud", ctr_u_d, 1);
        chk("rst_din", ctr_d_in, 0);
        chk("rst_cs", mem_cs, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Fault-free run: latency, busy window and address trace
        run_test(1'b0, lat, bcnt);
        chk("ff_latency", lat, LAT);
        chk("ff_busy_cycles", bcnt, LAT);
        chk("ff_fail", fail, 0);
        chk("ff_done", done, 1);
        chk("e0_load_ld", tr_ld[0], 1);
        chk("e0_load_din", tr_din[0], 0);
        chk("e0_load_ud", tr_ud[0], 1);
        for (int i = 0; i < 4; i++) begin
            chk("e0_addr", tr_addr[1+i], i);
            chk("e0_write", {tr_cs[1+i], tr_we[1+i]}, 2'b11);
            chk("e0_wdata", tr_wd[1+i], 8'h00);
        end
        chk("e1_r0_read", {tr_cs[6], tr_we[6]}, 2'b10);
        chk("e1_w1_wdata", tr_wd[7], 8'hFF);
        chk("e1_w1_we", tr_we[7], 1);
        chk("e3_load_ld", tr_ld[23], 1);
        chk("e3_load_din", tr_din[23], 3);
        chk("e3_load_ud", tr_ud[23], 0);
        for (int i = 0; i < 4; i++) chk("e3_addr", tr_addr[24+2*i], 3 - i);
        ldn = 0;
        for (int k = 0; k <= LAT; k++) if (tr_ld[k]) ldn++;
        chk("ld_pulses", ldn, 6);
        chk("drain_busy", tr_busy[LAT-1], 1);
        chk("drain_cen", tr_cen[LAT-1], 0);
        chk("done_busy", tr_busy[LAT], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold_q", ctr_q, 3);
        chk("done_hold_cen", ctr_cen, 0);
        chk("done_sticky", done, 1);

        // Stuck-at-1 on bit 0 of word 2: first miscompare on e1 r0 @2
        stuck = 1'b1;
        run_test(1'b0, lat, bcnt);
        chk("sa_latency", lat, LAT);
        chk("sa_fail_before", tr_fail[11], 0);
        chk("sa_fail_after", tr_fail[12], 1);
        chk("sa_fail_end", fail, 1);
`ifdef MBIST_DIAG_EN
        chk("sa_fail_addr", fail_addr, 2);
        chk("sa_fail_elem", fail_elem, 1);
        chk("sa_syndrome", fail_syndrome, 8'h01);
        chk("sa_fail_cnt", fail_cnt, 3);
`endif

        // start held high through a faulty run, then re-pulse fault-free
        run_test(1'b1, lat, bcnt);
        chk("hold_latency", lat, LAT);
        chk("hold_busy_cycles", bcnt, LAT);
        chk("hold_fail", fail, 1);
        @(negedge clk);
        stuck = 1'b0;
        run_test(1'b0, lat, bcnt);
        chk("rerun_done_clr", tr_done[0], 0);
        chk("rerun_fail_clr", tr_fail[0], 0);
        chk("rerun_latency", lat, LAT);
        chk("rerun_fail", fail, 0);
`ifdef MBIST_DIAG_EN
        chk("rerun_fail_cnt", fail_cnt, 0);
`endif

        // Asynchronous reset in the middle of a faulty run
        @(negedge clk);
        stuck = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy_pre", busy, 1);
        chk("mid_fail_pre", fail, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_fail", fail, 0);
        chk("arst_done", done, 0);
        chk("arst_cen", ctr_cen, 0);
        chk("arst_cs", mem_cs, 0);
        chk("arst_ud", ctr_u_d, 1);
        @(negedge clk);
        rst_n = 1'b1;
        stuck = 1'b0;
        @(negedge clk);
        run_test(1'b0, lat, bcnt);
        chk("post_rst_latency", lat, LAT);
        chk("post_rst_fail", fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
